// File: rtl/mult_accum.sv
// mult_accum: accumulates a stream of unsigned products into a wide sum.
//
// One sequence of product beats (closed by prod_last) is summed into an
// ACC_W-bit accumulator. The result (sum, saturating beat count, sticky
// overflow) is presented on a valid/ready port until it is taken. Then the
// block returns to idle and accepts the next sequence.
//
// Optional feature macro: MULT_ACC_SAT_EN
//   defined   - on carry out of ACC_W the sum clamps to 2^ACC_W-1
//   undefined - the sum wraps modulo 2^ACC_W
//   In both cases acc_ovf records the carry.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   prod_valid/ready product beat handshake
//   prod_data        unsigned product beat
//   prod_last        beat closes the sequence
//   acc_valid/ready  result handshake
//   acc_data         accumulated sum
//   acc_count        beats in the sequence (saturating)
//   acc_ovf          sticky overflow for the sequence
module mult_accum #(
  parameter int unsigned PROD_W = 9,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W:0]     sum;
  logic               accept;

  // Outputs decode registered state only; no path from prod_* to acc_valid.
  assign acc_valid  = (state_q == StHold);
  assign prod_ready = (state_q != StHold);
  assign acc_data   = acc_q;
  assign acc_count  = cnt_q;
  assign acc_ovf    = ovf_q;

  assign accept = prod_valid & prod_ready;
  // One extra bit catches the carry out of the accumulator.
  assign sum    = {1'b0, acc_q} + (ACC_W+1)'(prod_data);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = ACC_W'(prod_data);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = prod_last ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
`ifdef MULT_ACC_SAT_EN
          // Once clamped, every further nonzero beat carries again, so the
          // sum stays pinned at full scale for the rest of the sequence.
          acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          ovf_d = ovf_q | sum[ACC_W];
          if (prod_last) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (acc_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mult_accum.sv
// Self-checking bench for mult_accum (instantiated with ACC_W=10 so that
// overflow is reachable with a handful of beats). A sequence-level model
// sums accepted beats and queues the expected result; a negedge process
// compares DUT outputs with it every cycle. Directed tests add literal checks.
module tb_mult_accum;
  localparam int unsigned PROD_W = 9;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned CNT_W  = 4;
  localparam longint      AccMax = (64'd1 << ACC_W) - 1;
  localparam longint      CntMax = (64'd1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              prod_valid = 1'b0;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data = '0;
  logic              prod_last = 1'b0;
  logic              acc_valid;
  logic              acc_ready = 1'b0;
  logic [ACC_W-1:0]  acc_data;
  logic [CNT_W-1:0]  acc_count;
  logic              acc_ovf;

  int errors = 0;
  int checks = 0;

  mult_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_count  (acc_count),
    .acc_ovf    (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    longint data;
    longint cnt;
    longint ovf;
  } res_t;

  res_t   exp_q[$];
  longint m_sum = 0;
  longint m_n   = 0;

  function automatic res_t seq_result(input longint s, input longint n);
    res_t r;
`ifdef MULT_ACC_SAT_EN
    r.data = (s > AccMax) ? AccMax : s;
`else
    r.data = s % (AccMax + 1);
`endif
    r.cnt = (n > CntMax) ? CntMax : n;
    r.ovf = (s > AccMax) ? 1 : 0;
    return r;
  endfunction

  // Inputs change only just after posedge, so negedge sees what the next
  // posedge will see.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_sum = 0;
      m_n   = 0;
    end else begin
      chk("acc_valid", acc_valid, exp_q.size() != 0);
      chk("prod_ready", prod_ready, exp_q.size() == 0);
      if (exp_q.size() != 0) begin
        chk("model_data", acc_data, exp_q[0].data);
        chk("model_count", acc_count, exp_q[0].cnt);
        chk("model_ovf", acc_ovf, exp_q[0].ovf);
        if (acc_valid && acc_ready) void'(exp_q.pop_front());
      end
      if (prod_valid && prod_ready) begin
        m_sum += longint'(prod_data);
        m_n++;
        if (prod_last) begin
          exp_q.push_back(seq_result(m_sum, m_n));
          m_sum = 0;
          m_n   = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted.
  task automatic beat(input logic [PROD_W-1:0] d, input logic last);
    bit took = 1'b0;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = last;
    for (int i = 0; i < 20; i++) begin
      took = prod_ready;
      step();
      if (took) break;
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    if (!took) chk("beat_timeout", 0, 1);
  endtask

  // Wait for a result while holding it back, check literals, then take it.
  task automatic take(input string name, input longint d, input longint c,
                      input longint o);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (acc_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({name, "_valid"}, seen, 1);
    chk({name, "_data"}, acc_data, d);
    chk({name, "_count"}, acc_count, c);
    chk({name, "_ovf"}, acc_ovf, o);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  initial begin
    logic [ACC_W-1:0] held_data;
    logic [CNT_W-1:0] held_cnt;

    // Reset state
    #2;
    chk("rst_data", acc_data, 0);
    chk("rst_count", acc_count, 0);
    chk("rst_ovf", acc_ovf, 0);
    chk("rst_valid", acc_valid, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", prod_ready, 1);

    // 1: single beat
    beat(9'h051, 1'b1);
    chk("t1_valid_next", acc_valid, 1);
    take("t1", 64'h51, 1, 0);

    // 2: four back-to-back beats of 225
    for (int i = 0; i < 4; i++) begin
      chk("t2_not_valid", acc_valid, 0);
      beat(9'h0E1, i == 3);
    end
    chk("t2_valid_next", acc_valid, 1);
    take("t2", 900, 4, 0);

    // 3: overflow, 5 x 225 = 1125 into 10 bits
    for (int i = 0; i < 5; i++) beat(9'd225, i == 4);
`ifdef MULT_ACC_SAT_EN
    take("t3", 1023, 5, 1);
`else
    take("t3", 101, 5, 1);
`endif

    // 4: backpressure in HOLD with a new beat pending
    beat(9'd7, 1'b1);
    held_data  = acc_data;
    held_cnt   = acc_count;
    prod_valid = 1'b1;
    prod_data  = 9'd3;
    prod_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_ready_low", prod_ready, 0);
      chk("t4_data_stable", acc_data, held_data);
      chk("t4_count_stable", acc_count, held_cnt);
      step();
    end
    chk("t4_held_data", held_data, 7);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    chk("t4_idle_ready", prod_ready, 1);
    chk("t4_idle_valid", acc_valid, 0);
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    take("t4b", 3, 1, 0);

    // 5: count saturation
    for (int i = 0; i < 20; i++) beat(9'd1, i == 19);
    take("t5", 20, 15, 0);

    // 6: reset mid-sequence
    beat(9'd4, 1'b0);
    beat(9'd4, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_data", acc_data, 0);
    chk("t6_rst_count", acc_count, 0);
    chk("t6_rst_ovf", acc_ovf, 0);
    chk("t6_rst_valid", acc_valid, 0);
    step();
    rst = 1'b0;
    step();
    beat(9'd9, 1'b1);
    take("t6", 9, 1, 0);

    // Mixed sequences with varied gaps, checked by the model only
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i <= s; i++) begin
        if ((i % 2) == 1) step();
        beat(PROD_W'((s * 37 + i * 91) % 512), i == s);
      end
      acc_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      acc_ready = 1'b0;
    end

    step();
    chk("end_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
